mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported unified memory bus between instruction fetch (IF) and the MEM-stage load/store.
// - Sits after the EX/MEM pipeline register: consumes the MEM-stage control, address and store data.
// - Produces hold (stall) requests for the IF and MEM pipeline stages.
// - Formats byte enables and store data, and extracts/sign-extends load data.
// PARAMETERS
// - MEM_STREAK   4    max consecutive MEM grants while IF waits; the next grant goes to IF
// - ACK_TIMEOUT  255  cycles spent in an access state with no bus_ack before abort (8-bit counter)
// PORTS
// - clk          in   1   clock
// - rst          in   1   reset, asynchronous, active-high
// - if_req       in   1   fetch request; held until if_valid
// - if_addr      in   32  fetch address (word aligned; [1:0] ignored)
// - flush        in   1   pipeline flush; kills an in-flight fetch result
// - if_rdata     out  32  fetched instruction; valid only when if_valid=1
// - if_valid     out  1   one-cycle pulse: fetch complete
// - mem_rd_M     in   1   MEM-stage load
// - mem_wr_M     in   1   MEM-stage store (never asserted together with mem_rd_M)
// - mem_mask_M   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - addr_M       in   32  MEM-stage byte address (ALU result)
// - wdata_M      in   32  store data, LSB-aligned
// - mem_rdata_M  out  32  extended load data; valid only when mem_done_M=1
// - mem_done_M   out  1   one-cycle pulse: MEM access complete
// - stall_IF     out  1   = if_req & ~if_valid
// - stall_MEM    out  1   = (mem_rd_M | mem_wr_M) & ~mem_done_M; holds all stages up to and including EX/MEM
// - misalign     out  1   one-cycle pulse: misaligned MEM access rejected
// - bus_err      out  1   one-cycle pulse: access aborted by timeout
// - bus_req      out  1   bus request (registered)
// - bus_we       out  1   1 = write (registered)
// - bus_addr     out  32  word address {addr[31:2], 2'b00} (registered)
// - bus_be       out  4   byte enables (registered)
// - bus_wdata    out  32  replicated store data (registered)
// - bus_rdata    in   32  bus read data; valid with bus_ack
// - bus_ack      in   1   access complete, sampled only while bus_req=1
// BEHAVIOUR
// - Reset values: state=IDLE; all registered outputs 0, streak counter 0, timeout counter 0, kill flag 0.
//   Every pulse output is 0 and rdata outputs are 0 during reset.
// - FSM states: IDLE, IF_ACC, MEM_ACC.
// - IDLE arbitration:
//   - MEM pending (rd|wr) and aligned, with (~if_req or streak<MEM_STREAK): go to MEM_ACC.
//   - Otherwise, if if_req: go to IF_ACC.
//   - On entry to either access state: bus_* registered at that edge; bus_req=1 from the next cycle.
// - Streak counter:
//   - MEM grant with if_req=1: +1 (saturates at MEM_STREAK).
//   - IF grant, or if_req=0 in IDLE: clears to 0.
// - Access states:
//   - bus_* held stable until bus_ack.
//   - On the bus_ack cycle: complete the access, bus_req=0 at the next edge, return to IDLE.
//   - No back-to-back grant: each access costs at least 2 cycles (IDLE plus the ack cycle).
// - Completion in MEM_ACC: mem_done_M=1 combinationally with bus_ack; mem_rdata_M derived from bus_rdata in the same cycle.
//   - stall_MEM drops in that cycle, so the pipeline advances at the next edge.
// - Completion in IF_ACC: if_valid=1 and if_rdata=bus_rdata, unless the kill flag is set.
//   - Kill set: if_valid stays 0 and the result is discarded.
// - Kill flag: set by flush while in IF_ACC (including the ack cycle); cleared on return to IDLE.
//   - flush in IDLE or MEM_ACC has no effect; a MEM access is never aborted by flush.
// - Byte enables:
//   - B: 4'b0001 << a[1:0].
//   - H: 4'b0011 << {a[1],1'b0}.
//   - W: 4'b1111.
//   - IF accesses: 4'b1111, bus_we=0.
// - Store data replication:
//   - B: {4{wdata[7:0]}}.
//   - H: {2{wdata[15:0]}}.
//   - W: wdata.
// - Load data: select the byte/half at the addressed lane; sign-extend for B/H, zero-extend for BU/HU.
// - Misaligned access (H/HU with a[0]=1, or W with a[1:0]!=0), detected in IDLE:
//   - No bus access.
//   - mem_done_M=1, misalign=1, mem_rdata_M=0 in that cycle.
//   - State stays IDLE.
// - Timeout: the counter counts cycles in an access state without bus_ack.
//   - At ACK_TIMEOUT, force completion: bus_err=1; rdata outputs 0; done/valid pulse as normal.
//   - bus_req=0 next edge; go to IDLE.
//   - bus_ack arriving in the same cycle as the timeout wins: normal completion, no bus_err.
// - Reset mid-access: immediate return to IDLE with bus_req=0; the in-flight access result is lost.
// TESTING
// - Load LW at 0x100, bus_ack 2 cycles after bus_req, rdata 0xDEADBEEF:
//   mem_done_M pulses once with 0xDEADBEEF; stall_MEM high for 3 cycles.
// - LB at 0x103, bus_rdata 0x80112233:
//   bus_be=4'b1000, mem_rdata_M=0xFFFFFF80. LBU at the same address: 0x00000080.
// - SH at 0x202, wdata 0x0000ABCD:
//   bus_be=4'b1100, bus_wdata=0xABCDABCD, bus_we=1, bus_addr=0x200.
// - if_req held with a MEM request every cycle, MEM_STREAK=4:
//   the 5th grant goes to IF; if_valid pulses; streak returns to 0.
// - flush during IF_ACC, ack 1 cycle later:
//   no if_valid pulse; the next if_req is granted normally.
// - LW at 0x101 gives a misalign pulse with no bus_req.
//   No bus_ack for 255 cycles gives a bus_err pulse, mem_done_M=1 with rdata 0, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between instruction
// fetch and the MEM-stage load/store, issues stage holds, formats byte
// enables / store data and extends load data.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req, if_addr, flush        fetch request, fetch address, pipeline flush
//   if_rdata, if_valid            fetched instruction and its completion pulse
//   mem_rd_M, mem_wr_M            MEM-stage load / store request
//   mem_mask_M, addr_M, wdata_M   funct3 size code, byte address, store data
//   mem_rdata_M, mem_done_M       extended load data and completion pulse
//   stall_IF, stall_MEM           hold requests for the IF and MEM stages
//   misalign, bus_err             misaligned-reject and timeout-abort pulses
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata             registered bus request
//   bus_rdata, bus_ack            bus read data and completion
module mem_port_arbiter #(
  parameter int unsigned MEM_STREAK  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  mem_mask_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic [31:0] mem_rdata_M,
  output logic        mem_done_M,
  output logic        stall_IF,
  output logic        stall_MEM,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned STREAK_W = $clog2(MEM_STREAK + 1);
  localparam int unsigned TO_W     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                kill_q, kill_d;
  logic                req_d, we_d;
  logic [31:0]         addr_d, wdata_d;
  logic [3:0]          be_d;

  logic        ack_v, mem_pend, is_word, is_half, mis_c;
  logic        in_acc, timeout, fin;
  logic [3:0]  mem_be;
  logic [31:0] mem_wrep, load_ext;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        unused_bits;

  // Fetch addresses are word aligned; the low bits carry no information.
  assign unused_bits = ^if_addr[1:0];

  // Size decode shared by enables, replication and misalignment.
  assign is_word  = mem_mask_M[1];
  assign is_half  = ~mem_mask_M[1] & mem_mask_M[0];
  assign mem_pend = mem_rd_M | mem_wr_M;
  assign mis_c    = (is_half & addr_M[0]) | (is_word & (|addr_M[1:0]));

  // Byte enables and replicated store data for MEM accesses.
  always_comb begin
    if (is_word) begin
      mem_be   = 4'b1111;
      mem_wrep = wdata_M;
    end else if (is_half) begin
      mem_be   = 4'b0011 << {addr_M[1], 1'b0};
      mem_wrep = {2{wdata_M[15:0]}};
    end else begin
      mem_be   = 4'b0001 << addr_M[1:0];
      mem_wrep = {4{wdata_M[7:0]}};
    end
  end

  // Lane select and sign/zero extension of load data.
  always_comb begin
    case (addr_M[1:0])
      2'd0:    lane_byte = bus_rdata[7:0];
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      default: lane_byte = bus_rdata[31:24];
    endcase
    lane_half = addr_M[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (mem_mask_M)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = bus_rdata;
    endcase
  end

  // Completion: ack wins over a timeout landing in the same cycle.
  assign ack_v   = bus_ack & bus_req;
  assign in_acc  = (state_q != IDLE);
  assign timeout = in_acc & ~ack_v & (to_q == TO_W'(ACK_TIMEOUT));
  assign fin     = in_acc & (ack_v | timeout);

  assign misalign    = (state_q == IDLE) & mem_pend & mis_c;
  assign bus_err     = timeout;
  assign mem_done_M  = ((state_q == MEM_ACC) & fin) | misalign;
  assign mem_rdata_M = ((state_q == MEM_ACC) & ack_v) ? load_ext : 32'd0;
  // A flush on the ack cycle also kills the result.
  assign if_valid    = (state_q == IF_ACC) & fin & ~kill_q & ~flush;
  assign if_rdata    = (if_valid & ack_v) ? bus_rdata : 32'd0;
  assign stall_IF    = if_req & ~if_valid;
  assign stall_MEM   = mem_pend & ~mem_done_M;

  // Next state, arbitration, counters and bus request formation.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    to_d     = to_q;
    kill_d   = kill_q;
    req_d    = bus_req;
    we_d     = bus_we;
    addr_d   = bus_addr;
    be_d     = bus_be;
    wdata_d  = bus_wdata;
    case (state_q)
      IDLE: begin
        to_d   = '0;
        kill_d = 1'b0;
        if (!if_req) streak_d = '0;
        if (mem_pend && mis_c) begin
          // Rejected in place; no bus cycle and no grant this cycle.
          state_d = IDLE;
        end else if (mem_pend && (!if_req || streak_q < STREAK_W'(MEM_STREAK))) begin
          state_d = MEM_ACC;
          req_d   = 1'b1;
          we_d    = mem_wr_M;
          addr_d  = {addr_M[31:2], 2'b00};
          be_d    = mem_be;
          wdata_d = mem_wrep;
          if (if_req) streak_d = streak_q + STREAK_W'(1);
        end else if (if_req) begin
          state_d  = IF_ACC;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = {if_addr[31:2], 2'b00};
          be_d     = 4'b1111;
          wdata_d  = 32'd0;
          streak_d = '0;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (state_q == IF_ACC && flush) kill_d = 1'b1;
        if (fin) begin
          state_d = IDLE;
          req_d   = 1'b0;
          to_d    = '0;
          kill_d  = 1'b0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      to_q      <= '0;
      kill_q    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      to_q      <= to_d;
      kill_q    <= kill_d;
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_be    <= be_d;
      bus_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// loads/stores checked against a size/lane arithmetic reference model.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, flush;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic        mem_rd_M, mem_wr_M;
  logic [2:0]  mem_mask_M;
  logic [31:0] addr_M, wdata_M, mem_rdata_M;
  logic        mem_done_M, stall_IF, stall_MEM, misalign, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          stall_cnt;
    int          done_cnt;
    int          err_cnt;
    int          mis_cnt;
    int          done_idx;
    logic        saw_req;
    logic        req_after;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] addr;
  } obs_t;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M), .mem_mask_M(mem_mask_M),
    .addr_M(addr_M), .wdata_M(wdata_M),
    .mem_rdata_M(mem_rdata_M), .mem_done_M(mem_done_M),
    .stall_IF(stall_IF), .stall_MEM(stall_MEM),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned sz(input logic [2:0] m);
    return m[1] ? 4 : (m[0] ? 2 : 1);
  endfunction

  function automatic bit exp_mis(input logic [2:0] m, input logic [31:0] a);
    return (int'(a[1:0]) % sz(m)) != 0;
  endfunction

  function automatic int unsigned lane_of(input logic [2:0] m, input logic [31:0] a);
    return (int'(a[1:0]) / sz(m)) * sz(m);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] m, input logic [31:0] a);
    int unsigned s;
    s = sz(m);
    return 4'(((1 << s) - 1) << lane_of(m, a));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] m, input logic [31:0] w);
    if (sz(m) == 1) return 32'(w[7:0]) * 32'h0101_0101;
    if (sz(m) == 2) return 32'(w[15:0]) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] m, input logic [31:0] a,
                                          input logic [31:0] r);
    int unsigned s;
    logic [31:0] v, span;
    s = sz(m);
    if (s == 4) return r;
    span = 32'((64'd1 << (8 * s)) - 64'd1);
    v = (r >> (8 * lane_of(m, a))) & span;
    if (!m[2] && v > (span >> 1)) v = v - (span + 32'd1);
    return v;
  endfunction

  // ---------------- stimulus driver ----------------
  // Drives one MEM op, acks ack_lat cycles after bus_req rises (<0: never),
  // and reports what the DUT did.
  task automatic run_mem(input logic rd, input logic wr, input logic [2:0] mask,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int ack_lat, output obs_t o);
    int ri;
    bit fin;
    o.stall_cnt = 0; o.done_cnt = 0; o.err_cnt = 0; o.mis_cnt = 0; o.done_idx = -2;
    o.saw_req = 0; o.req_after = 0; o.rdata = '0; o.be = '0; o.wd = '0; o.we = 0; o.addr = '0;
    ri = -1;
    fin = 0;
    @(negedge clk);
    mem_rd_M = rd; mem_wr_M = wr; mem_mask_M = mask; addr_M = a; wdata_M = wd;
    bus_rdata = rdat; bus_ack = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (bus_req) ri++;
      bus_ack = bus_req && (ri == ack_lat);
      #1;
      if (bus_req) begin
        o.saw_req = 1;
        if (ri == 0) begin
          o.be = bus_be; o.wd = bus_wdata; o.we = bus_we; o.addr = bus_addr;
        end
      end
      if (stall_MEM) o.stall_cnt++;
      if (misalign) o.mis_cnt++;
      if (bus_err) o.err_cnt++;
      if (mem_done_M) begin
        o.done_cnt++;
        o.rdata = mem_rdata_M;
        o.done_idx = ri;
        fin = 1;
      end
    end
    @(negedge clk);
    mem_rd_M = 0; mem_wr_M = 0; bus_ack = 0;
    #1;
    o.req_after = bus_req;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; if_req = 0; if_addr = 0; flush = 0; mem_rd_M = 0; mem_wr_M = 0;
    mem_mask_M = 0; addr_M = 0; wdata_M = 0; bus_rdata = 32'hFFFF_FFFF; bus_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus_req, bus_we, bus_be} !== 6'd0) begin
      errors++; $display("FAIL reset_bus_ctl got %b exp 0", {bus_req, bus_we, bus_be});
    end
    checks++;
    if ({bus_addr, bus_wdata} !== 64'd0) begin
      errors++; $display("FAIL reset_bus_data got %h exp 0", {bus_addr, bus_wdata});
    end
    checks++;
    if ({if_valid, mem_done_M, misalign, bus_err} !== 4'd0) begin
      errors++; $display("FAIL reset_pulses got %b exp 0000", {if_valid, mem_done_M, misalign, bus_err});
    end
    checks++;
    if ({mem_rdata_M, if_rdata} !== 64'd0) begin
      errors++; $display("FAIL reset_rdata got %h exp 0", {mem_rdata_M, if_rdata});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_load_word();
    obs_t o;
    run_mem(1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 2, o);
    checks++;
    if (o.done_cnt !== 1) begin errors++; $display("FAIL lw_done_cnt got %0d exp 1", o.done_cnt); end
    checks++;
    if (o.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", o.rdata); end
    checks++;
    if (o.stall_cnt !== 3) begin errors++; $display("FAIL lw_stall got %0d exp 3", o.stall_cnt); end
    checks++;
    if ({o.addr, o.be, o.we} !== {32'h100, 4'hF, 1'b0}) begin
      errors++; $display("FAIL lw_bus got addr %h be %b we %b exp 100 1111 0", o.addr, o.be, o.we);
    end
    checks++;
    if (o.req_after !== 1'b0) begin errors++; $display("FAIL lw_req_drop got %b exp 0", o.req_after); end
  endtask

  task automatic test_byte_loads();
    obs_t o;
    run_mem(1, 0, 3'b000, 32'h103, 0, 32'h8011_2233, 1, o);
    checks++;
    if (o.be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", o.be); end
    checks++;
    if (o.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", o.rdata); end
    run_mem(1, 0, 3'b100, 32'h103, 0, 32'h8011_2233, 0, o);
    checks++;
    if (o.rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", o.rdata); end
  endtask

  task automatic test_store_half();
    obs_t o;
    run_mem(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 1, o);
    checks++;
    if (o.be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", o.be); end
    checks++;
    if (o.wd !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", o.wd); end
    checks++;
    if ({o.we, o.addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL sh_we_addr got we %b addr %h exp 1 200", o.we, o.addr);
    end
    checks++;
    if (o.done_cnt !== 1) begin errors++; $display("FAIL sh_done got %0d exp 1", o.done_cnt); end
  endtask

  task automatic test_streak();
    string got, exp;
    int s, vcnt, dcnt;
    logic prev;
    exp = "";
    s = 0;
    for (int k = 0; k < 10; k++) begin
      if (s < 4) begin exp = {exp, "M"}; s++; end
      else begin exp = {exp, "I"}; s = 0; end
    end
    got = ""; vcnt = 0; dcnt = 0; prev = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h1000; mem_rd_M = 1; mem_mask_M = 3'b010; addr_M = 32'h300;
    bus_rdata = 32'h1234_5678;
    for (int c = 0; c < 200 && got.len() < 10; c++) begin
      if (c > 0) @(negedge clk);
      bus_ack = bus_req;
      #1;
      if (bus_req && !prev) got = {got, (bus_addr == 32'h1000) ? "I" : "M"};
      if (if_valid) vcnt++;
      if (mem_done_M) dcnt++;
      prev = bus_req;
    end
    @(negedge clk);
    if_req = 0; mem_rd_M = 0; bus_ack = 0;
    checks++;
    if (got != exp) begin errors++; $display("FAIL streak_order got %s exp %s", got, exp); end
    checks++;
    if (vcnt !== 2) begin errors++; $display("FAIL streak_if_valid got %0d exp 2", vcnt); end
    checks++;
    if (dcnt !== 8) begin errors++; $display("FAIL streak_mem_done got %0d exp 8", dcnt); end
  endtask

  task automatic test_flush();
    int vcnt;
    vcnt = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h2000; flush = 0; bus_ack = 0;
    #1;
    @(negedge clk);
    flush = 1;
    #1;
    checks++;
    if ({bus_req, bus_addr, stall_IF} !== {1'b1, 32'h2000, 1'b1}) begin
      errors++; $display("FAIL flush_grant got req %b addr %h stall %b exp 1 2000 1", bus_req, bus_addr, stall_IF);
    end
    if (if_valid) vcnt++;
    @(negedge clk);
    flush = 0; bus_ack = 1; bus_rdata = 32'h0000_0013;
    #1;
    if (if_valid) vcnt++;
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL flush_kill got %0d if_valid pulses exp 0", vcnt); end
    @(negedge clk);
    bus_ack = 0; if_addr = 32'h2004;
    #1;
    checks++;
    if ({bus_req, if_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_idle got req %b valid %b exp 0 0", bus_req, if_valid);
    end
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h0000_0093;
    #1;
    checks++;
    if ({bus_req, bus_addr, if_valid, if_rdata, stall_IF} !== {1'b1, 32'h2004, 1'b1, 32'h93, 1'b0}) begin
      errors++; $display("FAIL flush_refetch got req %b addr %h valid %b rdata %h stall %b exp 1 2004 1 93 0",
                         bus_req, bus_addr, if_valid, if_rdata, stall_IF);
    end
    @(negedge clk);
    if_req = 0; bus_ack = 0;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_mem(1, 0, 3'b010, 32'h101, 0, 32'hCAFE_F00D, 0, o);
    checks++;
    if ({o.mis_cnt, o.done_cnt} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL mis_pulse got mis %0d done %0d exp 1 1", o.mis_cnt, o.done_cnt);
    end
    checks++;
    if ({o.saw_req, o.rdata} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL mis_nobus got req %b rdata %h exp 0 0", o.saw_req, o.rdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_mem(1, 0, 3'b010, 32'h500, 0, 32'h5555_AAAA, -1, o);
    checks++;
    if ({o.err_cnt, o.done_cnt} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL to_pulses got err %0d done %0d exp 1 1", o.err_cnt, o.done_cnt);
    end
    checks++;
    if (o.rdata !== 32'd0) begin errors++; $display("FAIL to_rdata got %h exp 0", o.rdata); end
    checks++;
    if (o.done_idx !== 255) begin errors++; $display("FAIL to_cycle got %0d exp 255", o.done_idx); end
    checks++;
    if (o.req_after !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b exp 0", o.req_after); end
    // Late ack racing the timeout: ack wins.
    run_mem(1, 0, 3'b010, 32'h504, 0, 32'h0BAD_CAFE, 255, o);
    checks++;
    if ({o.err_cnt, o.rdata} !== {32'd0, 32'h0BAD_CAFE}) begin
      errors++; $display("FAIL to_ack_wins got err %0d rdata %h exp 0 0badcafe", o.err_cnt, o.rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    @(negedge clk);
    mem_rd_M = 1; mem_mask_M = 3'b010; addr_M = 32'h400;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      seen = bus_req;
    end
    rst = 1;
    #1;
    checks++;
    if ({seen, bus_req, mem_done_M} !== 3'b100) begin
      errors++; $display("FAIL rst_mid got seen %b req %b done %b exp 1 0 0", seen, bus_req, mem_done_M);
    end
    @(negedge clk);
    rst = 0; mem_rd_M = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] masks [5];
    logic [2:0] m;
    logic [31:0] a, w, r, er;
    logic wr;
    int lat;
    bit mis;
    masks = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      m = masks[$urandom_range(0, 4)];
      wr = 1'($urandom_range(0, 1));
      if (wr) m = {1'b0, m[1:0]};
      a = $urandom; w = $urandom; r = $urandom;
      lat = $urandom_range(0, 3);
      mis = exp_mis(m, a);
      run_mem(~wr, wr, m, a, w, r, lat, o);
      checks++;
      if ({o.done_cnt, o.mis_cnt} !== {32'd1, mis ? 32'd1 : 32'd0}) begin
        errors++; $display("FAIL rnd%0d_done got done %0d mis %0d exp 1 %0d", i, o.done_cnt, o.mis_cnt, mis);
      end
      if (mis) begin
        checks++;
        if ({o.saw_req, o.rdata, o.stall_cnt} !== {1'b0, 32'd0, 32'd0}) begin
          errors++; $display("FAIL rnd%0d_mis got req %b rdata %h stall %0d exp 0 0 0", i, o.saw_req, o.rdata, o.stall_cnt);
        end
      end else begin
        checks++;
        if ({o.addr, o.be, o.we} !== {a & 32'hFFFF_FFFC, exp_be(m, a), wr}) begin
          errors++; $display("FAIL rnd%0d_bus got addr %h be %b we %b exp %h %b %b",
                             i, o.addr, o.be, o.we, a & 32'hFFFF_FFFC, exp_be(m, a), wr);
        end
        checks++;
        if (o.stall_cnt !== 1 + lat) begin
          errors++; $display("FAIL rnd%0d_stall got %0d exp %0d", i, o.stall_cnt, 1 + lat);
        end
        if (wr) begin
          checks++;
          if (o.wd !== exp_wd(m, w)) begin
            errors++; $display("FAIL rnd%0d_wdata got %h exp %h", i, o.wd, exp_wd(m, w));
          end
        end else begin
          er = exp_load(m, a, r);
          checks++;
          if (o.rdata !== er) begin
            errors++; $display("FAIL rnd%0d_rdata got %h exp %h (mask %b addr %h bus %h)", i, o.rdata, er, m, a, r);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_byte_loads();
    test_store_half();
    test_misalign();
    test_streak();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
